// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter width for an N-bit operand; never narrower than one bit.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/FA.sv
// rtl/FA.sv - single-bit full adder
module FA (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic half;

  assign half = A ^ B;
  assign Sum  = half ^ Cin;
  assign Cout = (A & B) | (Cin & half);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder step per clock
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  localparam int CW = count_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  sreg;
  logic          carry;
  logic [CW-1:0] count;
  logic          fa_sum;
  logic          fa_cout;

  FA u_fa (
    .A    (a_reg[0]),
    .B    (b_reg[0]),
    .Cin  (carry),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      sreg  <= '0;
      carry <= 1'b0;
      count <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            carry <= Cin;
            sreg  <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          a_reg <= {1'b0, a_reg[N-1:1]};
          b_reg <= {1'b0, b_reg[N-1:1]};
          sreg  <= {fa_sum, sreg[N-1:1]};
          carry <= fa_cout;
          // Last bit: publish the result including the bit produced this edge.
          if (count == LAST) begin
            Sum   <= {fa_sum, sreg[N-1:1]};
            Cout  <= fa_cout;
            count <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: N, default 8, operand width in bits (N >= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to add A, B, Cin; sampled only in IDLE.
REQ-005 Port: A  input  N  first operand, captured on accepted start.
REQ-006 Port: B  input  N  second operand, captured on accepted start.
REQ-007 Port: Cin  input  1  carry-in, captured on accepted start.
REQ-008 Port: busy  output  1  high while in SHIFT or DONE.
REQ-009 Port: done  output  1  one-cycle pulse; Sum/Cout valid and new.
REQ-010 Port: Sum  output  N  registered result of A+B+Cin (low N bits).
REQ-011 Port: Cout  output  1  registered carry-out of A+B+Cin.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 at edge 0 -> load A_reg=A, B_reg=B, carry=Cin, count=0, state=SHIFT; start=0 -> stay in IDLE.
REQ-014 SHIFT: each edge, one full-adder evaluation of (A_reg[0], B_reg[0], carry); its sum shifts into the MSB of an internal N-bit shift register (right shift); A_reg and B_reg shift right; carry takes the full-adder carry-out; count increments.
REQ-015 On the SHIFT edge where count reaches N-1 (edge N after acceptance), the block SHALL copy the completed shift register to Sum, copy the final carry to Cout, and go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE at edge N+1.
REQ-017 Latency: done is high in the cycle after edge N, i.e. N+1 cycles after start is sampled. Throughput: one addition per N+2 cycles with start held high.
REQ-018 start in SHIFT or DONE SHALL be ignored; in-flight operands SHALL NOT change.
REQ-019 Changes on A, B, Cin after acceptance SHALL NOT affect the result.
REQ-020 Sum and Cout SHALL hold their last result until the next completion, never showing partial results.
REQ-021 Result SHALL equal {Cout, Sum} = A + B + Cin as (N+1)-bit unsigned; wrap-around appears only as Cout=1.
REQ-022 busy SHALL be 0 in IDLE and 1 in SHIFT and DONE; done SHALL be 1 only in DONE.

Reset
REQ-023 rst=1 at an edge SHALL force state=IDLE; A_reg, B_reg, shift register, carry, count, Sum, Cout = 0; busy=0, done=0.
REQ-024 rst SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse and SHALL leave Sum and Cout at 0.
REQ-025 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Structure
REQ-026 The state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL be defined once in a shared package or header, serial_adder_pkg, for use by both RTL and the bench.
REQ-027 The per-bit addition SHALL be done by one instance of the team's existing full-adder sub-module FA (ports A, B, Cin, Sum, Cout), with no inline sum/carry logic in serial_adder.
REQ-028 The counter width SHALL be $clog2(N) bits, with the wrap condition count==N-1.

Verification (N=8)
REQ-029 A=8'h00, B=8'h00, Cin=0, start pulse -> done at cycle 9, Sum=8'h00, Cout=0, busy high in cycles 1-9.
REQ-030 A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1 (full carry ripple).
REQ-031 A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Cout=1; A=8'h5A, B=8'h3C, Cin=1 -> Sum=8'h97, Cout=0.
REQ-032 start re-pulsed with A=8'h01 at cycles 3 and 9 during an 8'h10+8'h20 add -> result Sum=8'h30, one done pulse only; start held high -> done at cycles 9, 19, 29.
REQ-033 rst asserted at cycle 4 of an 8'hFF+8'h01 add -> no done, Sum=8'h00, Cout=0, busy=0 next cycle; next start computes correctly.
REQ-034 Self-checking random run: 1000 random A, B, Cin -> every {Cout,Sum} matches A+B+Cin; done count equals accepted start count.
